biquad_coef_loader: RTL and testbench

- Coefficient writer for the biquad IIR filter.
- Accepts a 5-word coefficient set (b0, b1, b2, a1, a2) over a valid/ready stream and buffers it in a shadow bank.
- After the set is validated, drives all five filter coefficient inputs in a single atomic update.
- Sits between the control/host stream and the filter's b0..a2 inputs, so the filter never sees a half-written set.

---
 rtl/biquad_coef_loader.sv | 212 +++++++++++++++++++++
 tb/tb_biquad_coef_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_coef_loader
//  Description : Collects a five-word biquad coefficient set (b0, b1, b2,
//                a1, a2) from a valid/ready stream into a shadow bank and
//                commits all five filter coefficients on a single edge.
//                Optional macro COEF_STAB_CHECK_EN adds a stability-triangle
//                test on the shadow set before it is committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad_coef_loader #(
  parameter int IO_WIDTH = 16,
  parameter int RESET_B0 = 1,
  parameter int Q_ONE    = 16384
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IO_WIDTH-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  output logic signed [IO_WIDTH-1:0] b0,
  output logic signed [IO_WIDTH-1:0] b1,
  output logic signed [IO_WIDTH-1:0] b2,
  output logic signed [IO_WIDTH-1:0] a1,
  output logic signed [IO_WIDTH-1:0] a2,
  output logic                       coef_update,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [2:0] LAST_SLOT = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic                       update_q, update_d;
  logic                       err_q, err_d;
  logic                       err_set;
  logic                       stab_ok;
  logic                       shadow_we;
  logic [2:0]                 shadow_idx;
  logic                       xfer;
  logic signed [IO_WIDTH-1:0] shadow_q [0:4];
  logic signed [IO_WIDTH-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;

  assign xfer        = s_valid & s_ready;
  assign s_ready     = ready_q;
  assign coef_update = update_q;
  assign err         = err_q;
  assign b0          = b0_q;
  assign b1          = b1_q;
  assign b2          = b2_q;
  assign a1          = a1_q;
  assign a2          = a2_q;

`ifdef COEF_STAB_CHECK_EN
  // Two guard bits so |a| and Q_ONE + a2 can never wrap.
  localparam int EW = IO_WIDTH + 2;
  localparam logic signed [EW-1:0] Q_ONE_EXT = EW'(Q_ONE);

  logic signed [EW-1:0] a1_ext, a2_ext, a1_abs, a2_abs;

  assign a1_ext  = {{2{shadow_q[3][IO_WIDTH-1]}}, shadow_q[3]};
  assign a2_ext  = {{2{shadow_q[4][IO_WIDTH-1]}}, shadow_q[4]};
  assign a1_abs  = a1_ext[EW-1] ? -a1_ext : a1_ext;
  assign a2_abs  = a2_ext[EW-1] ? -a2_ext : a2_ext;
  assign stab_ok = (a2_abs < Q_ONE_EXT) && (a1_abs < (Q_ONE_EXT + a2_ext));
`else
  assign stab_ok = 1'b1;
`endif

  // State and word-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sequencing of the set and detection of framing errors.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (s_last) begin
            err_set = 1'b1;
            cnt_d   = 3'd0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = 3'd1;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == LAST_SLOT) begin
            cnt_d = 3'd0;
            if (s_last) begin
              state_d = S_CHECK;
            end else begin
              err_set = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s_last) begin
            err_set = 1'b1;
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && s_last) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (stab_ok) begin
          state_d = S_COMMIT;
        end else begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output logic: registered ready/pulse/err next values and shadow write control.
  always_comb begin
    ready_d    = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DRAIN);
    update_d   = (state_q == S_COMMIT);
    busy       = (state_q != S_IDLE);
    shadow_we  = xfer && ((state_q == S_IDLE) || (state_q == S_LOAD));
    shadow_idx = (state_q == S_IDLE) ? 3'd0 : cnt_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Handshake, update pulse and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  // Shadow bank: each accepted word lands in the slot selected by the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (shadow_we && (shadow_idx == 3'(i))) begin
          shadow_q[i] <= s_data;
        end
      end
    end
  end

  // Filter coefficient outputs: all five load together, only while committing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0_q <= IO_WIDTH'(RESET_B0);
      b1_q <= '0;
      b2_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (state_q == S_COMMIT) begin
      b0_q <= shadow_q[0];
      b1_q <= shadow_q[1];
      b2_q <= shadow_q[2];
      a1_q <= shadow_q[3];
      a2_q <= shadow_q[4];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biquad_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biquad_coef_loader
//  Description : Directed self-checking bench for biquad_coef_loader.
//                Define COEF_STAB_CHECK_EN to also exercise the stability test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biquad_coef_loader;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic                s_last = 1'b0;
  logic signed [W-1:0] b0, b1, b2, a1, a2;
  logic                coef_update;
  logic                busy;
  logic                err;
  logic                err_clr = 1'b0;

  int checks   = 0;
  int failures = 0;
  int exp_c [5];

  biquad_coef_loader #(
    .IO_WIDTH (W),
    .RESET_B0 (1),
    .Q_ONE    (16384)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .coef_update (coef_update),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Single comparison point used by every check.
  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Presents one word from a falling edge, waits (bounded) for the transfer,
  // returns on the falling edge after the accepting rising edge.
  task automatic send(input int d, input logic l, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = W'(d);
    s_last  = l;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=s_ready_low expected=s_ready_high");
    end
    @(posedge clk);
    @(negedge clk);
    if (l) s_valid = 1'b0;
  endtask

  task automatic expect_hold(input string tag);
    chk({tag, "_b0"}, b0, exp_c[0]);
    chk({tag, "_b1"}, b1, exp_c[1]);
    chk({tag, "_b2"}, b2, exp_c[2]);
    chk({tag, "_a1"}, a1, exp_c[3]);
    chk({tag, "_a2"}, a2, exp_c[4]);
    chk({tag, "_upd"}, coef_update, 0);
  endtask

  // Called right after the a2 word was accepted: outputs change two edges later.
  task automatic expect_commit(input string tag, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
    s_valid = 1'b0;
    chk({tag, "_rdy_e0"}, s_ready, 0);
    chk({tag, "_busy_e0"}, busy, 1);
    expect_hold({tag, "_e0"});
    @(negedge clk);
    chk({tag, "_rdy_e1"}, s_ready, 0);
    expect_hold({tag, "_e1"});
    @(negedge clk);
    exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3; exp_c[4] = e4;
    chk({tag, "_b0"}, b0, e0);
    chk({tag, "_b1"}, b1, e1);
    chk({tag, "_b2"}, b2, e2);
    chk({tag, "_a1"}, a1, e3);
    chk({tag, "_a2"}, a2, e4);
    chk({tag, "_upd_hi"}, coef_update, 1);
    chk({tag, "_rdy_e2"}, s_ready, 1);
    @(negedge clk);
    chk({tag, "_upd_lo"}, coef_update, 0);
  endtask

  task automatic expect_reset_vals(input string tag);
    chk({tag, "_b0"}, b0, 1);
    chk({tag, "_b1"}, b1, 0);
    chk({tag, "_b2"}, b2, 0);
    chk({tag, "_a1"}, a1, 0);
    chk({tag, "_a2"}, a2, 0);
    chk({tag, "_upd"}, coef_update, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, s_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and release
    repeat (3) @(negedge clk);
    expect_reset_vals("rst");
    chk("rst_err", err, 0);
    reset = 1'b1;
    #1;
    chk("rel_rdy_pre", s_ready, 0);
    @(negedge clk);
    chk("rel_rdy_post", s_ready, 1);
    chk("rel_err", err, 0);
    exp_c[0] = 1; exp_c[1] = 0; exp_c[2] = 0; exp_c[3] = 0; exp_c[4] = 0;

    // Back-to-back full set with s_valid held high
    send(100, 1'b0, 0);
    send(-200, 1'b0, 0);
    send(300, 1'b0, 0);
    send(-400, 1'b0, 0);
    send(500, 1'b1, 0);
    expect_commit("set1", 100, -200, 300, -400, 500);
    chk("set1_err", err, 0);

    // Short set: 3 words then s_last
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    send(3, 1'b1, 0);
    chk("short_err", err, 1);
    chk("short_busy", busy, 0);
    chk("short_rdy", s_ready, 1);
    expect_hold("short");
    send(11, 1'b0, 0);
    send(12, 1'b0, 0);
    send(13, 1'b0, 0);
    send(14, 1'b0, 0);
    send(15, 1'b1, 0);
    expect_commit("set2", 11, 12, 13, 14, 15);
    chk("set2_err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errclr", err, 0);

    // Lone s_last word in IDLE with err_clr on the same edge: set wins
    err_clr = 1'b1;
    send(7, 1'b1, 0);
    err_clr = 1'b0;
    chk("setwins_err", err, 1);
    expect_hold("setwins");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("setwins_clr", err, 0);

    // Long set: 7 words, s_last only on the 7th
    send(31, 1'b0, 0);
    send(32, 1'b0, 0);
    send(33, 1'b0, 0);
    send(34, 1'b0, 0);
    send(35, 1'b0, 0);
    chk("long_err", err, 1);
    chk("long_busy_drain", busy, 1);
    chk("long_rdy_drain", s_ready, 1);
    send(36, 1'b0, 0);
    send(37, 1'b1, 0);
    chk("long_busy_idle", busy, 0);
    chk("long_rdy_idle", s_ready, 1);
    chk("long_err_hold", err, 1);
    expect_hold("long");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Gapped partial set interrupted by reset after the 4th word
    send(41, 1'b0, $urandom_range(0, 3));
    send(42, 1'b0, $urandom_range(0, 3));
    send(43, 1'b0, $urandom_range(0, 3));
    send(44, 1'b0, $urandom_range(0, 3));
    chk("midrst_busy", busy, 1);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    expect_reset_vals("midrst");
    exp_c[0] = 1; exp_c[1] = 0; exp_c[2] = 0; exp_c[3] = 0; exp_c[4] = 0;
    @(negedge clk);
    chk("midrst_upd_held", coef_update, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", s_ready, 1);
    send(51, 1'b0, $urandom_range(0, 3));
    send(-52, 1'b0, $urandom_range(0, 3));
    send(53, 1'b0, $urandom_range(0, 3));
    send(-54, 1'b0, $urandom_range(0, 3));
    send(55, 1'b1, $urandom_range(0, 3));
    expect_commit("set3", 51, -52, 53, -54, 55);

`ifdef COEF_STAB_CHECK_EN
    // a2 == Q_ONE lies on the triangle edge: rejected
    send(1, 1'b0, 0);
    send(2, 1'b0, 0);
    send(3, 1'b0, 0);
    send(0, 1'b0, 0);
    send(16384, 1'b1, 0);
    s_valid = 1'b0;
    chk("stab_bad_rdy_e0", s_ready, 0);
    @(negedge clk);
    chk("stab_bad_err", err, 1);
    chk("stab_bad_upd_e1", coef_update, 0);
    @(negedge clk);
    expect_hold("stab_bad");
    chk("stab_bad_busy", busy, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    // |a1| = 20000 < 16384 + 8000: accepted
    send(5, 1'b0, 0);
    send(6, 1'b0, 0);
    send(7, 1'b0, 0);
    send(-20000, 1'b0, 0);
    send(8000, 1'b1, 0);
    expect_commit("stab_ok", 5, 6, 7, -20000, 8000);
    chk("stab_ok_err", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
